// File: rtl/fly_power_ctrl_pkg.sv
// Shared power-up definitions: flight state encoding, score width and the
// default frame constants used by the power-up controllers.
package fly_power_ctrl_pkg;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'd0,
    FP_GRANT  = 2'd1,
    FP_FLYING = 2'd2,
    FP_WARN   = 2'd3
  } fp_state_e;

  localparam int SCORE_W = 14;

  localparam int DEF_TIMER_W      = 10;
  localparam int DEF_FLY_FRAMES   = 600;
  localparam int DEF_WARN_FRAMES  = 120;
  localparam int DEF_GRANT_FRAMES = 30;
  localparam int DEF_BLINK_FRAMES = 4;
  localparam int DEF_SCORE_VALUE  = 1000;

endpackage

// File: rtl/fly_power_ctrl_blink_gen.sv
// Frame-tick blink generator: vis toggles every BLINK_FRAMES ticks and
// restarts visible with a cleared counter whenever restart is high.
module blink_gen #(
  parameter int BLINK_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic tick,
  input  logic restart,
  output logic vis
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!rst_b || restart) begin
      cnt <= '0;
      vis <= 1'b1;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        vis <= ~vis;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fly_power_ctrl.sv
// Flying power-up controller: pickup grant animation, timed flight window
// with warning blink, and enemy-hit arbitration.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   FP_NORMAL | no power-up; hits are fatal
//   FP_GRANT  | pickup animation: frozen, blinking, invulnerable
//   FP_FLYING | flight enabled, timer counting down
//   FP_WARN   | flight enabled, last frames, sprite blinking
module fly_power_ctrl
  import fly_power_ctrl_pkg::*;
#(
  parameter int TIMER_W      = DEF_TIMER_W,
  parameter int FLY_FRAMES   = DEF_FLY_FRAMES,
  parameter int WARN_FRAMES  = DEF_WARN_FRAMES,
  parameter int GRANT_FRAMES = DEF_GRANT_FRAMES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int SCORE_VALUE  = DEF_SCORE_VALUE
) (
  input  logic               sys_clk,
  input  logic               RST_N,
  input  logic               frame_tick,
  input  logic               touch_fly_ms,
  input  logic               char_hit,
  input  logic               level_rst,
  output logic               can_fly,
  output logic               freeze,
  output logic               sprite_vis,
  output logic [SCORE_W-1:0] score_add,
  output logic               score_vld,
  output logic               hit_absorbed,
  output logic               hit_fatal,
  output logic [TIMER_W-1:0] fly_timer
);

  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] GRANT_LOAD = TIMER_W'(GRANT_FRAMES);
  localparam logic [TIMER_W-1:0] FLY_LOAD   = TIMER_W'(FLY_FRAMES);
  localparam logic [TIMER_W-1:0] WARN_ENTRY = TIMER_W'(WARN_FRAMES + 1);

  fp_state_e          state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               score_nxt, absorbed_nxt, fatal_nxt;
  logic               blink_restart, blink_vis;

  always_ff @(posedge sys_clk) begin
    if (!RST_N) begin
      state        <= FP_NORMAL;
      timer        <= '0;
      score_vld    <= 1'b0;
      hit_absorbed <= 1'b0;
      hit_fatal    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      score_vld    <= score_nxt;
      hit_absorbed <= absorbed_nxt;
      hit_fatal    <= fatal_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    score_nxt     = 1'b0;
    absorbed_nxt  = 1'b0;
    fatal_nxt     = 1'b0;
    blink_restart = 1'b0;
    if (level_rst) begin
      state_nxt     = FP_NORMAL;
      timer_nxt     = '0;
      blink_restart = 1'b1;
    end else begin
      case (state)
        FP_NORMAL: begin
          if (char_hit) begin
            fatal_nxt = 1'b1;
          end else if (touch_fly_ms) begin
            state_nxt     = FP_GRANT;
            timer_nxt     = GRANT_LOAD;
            score_nxt     = 1'b1;
            blink_restart = 1'b1;
          end
        end
        FP_GRANT: begin
          // invulnerable: hits dropped, extra pickups only score
          score_nxt = touch_fly_ms;
          if (frame_tick) begin
            if (timer == TIMER_ONE) begin
              state_nxt = FP_FLYING;
              timer_nxt = FLY_LOAD;
            end else if (timer != '0) begin
              timer_nxt = timer - TIMER_ONE;
            end
          end
        end
        FP_FLYING, FP_WARN: begin
          if (char_hit) begin
            state_nxt    = FP_NORMAL;
            timer_nxt    = '0;
            absorbed_nxt = 1'b1;
          end else if (touch_fly_ms) begin
            state_nxt = FP_FLYING;
            timer_nxt = FLY_LOAD;
            score_nxt = 1'b1;
          end else if (frame_tick) begin
            if (state == FP_WARN && timer == TIMER_ONE) begin
              state_nxt = FP_NORMAL;
              timer_nxt = '0;
            end else if (state == FP_FLYING && timer == WARN_ENTRY) begin
              state_nxt     = FP_WARN;
              timer_nxt     = timer - TIMER_ONE;
              blink_restart = 1'b1;
            end else if (timer != '0) begin
              timer_nxt = timer - TIMER_ONE;
            end
          end
        end
        default: begin
          state_nxt = FP_NORMAL;
          timer_nxt = '0;
        end
      endcase
    end
  end

  blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk_sys (sys_clk),
    .rst_b   (RST_N),
    .tick    (frame_tick),
    .restart (blink_restart),
    .vis     (blink_vis)
  );

  assign can_fly    = (state == FP_FLYING) || (state == FP_WARN);
  assign freeze     = (state == FP_GRANT);
  assign sprite_vis = (state == FP_GRANT || state == FP_WARN) ? blink_vis : 1'b1;
  assign score_add  = score_vld ? SCORE_W'(SCORE_VALUE) : '0;
  assign fly_timer  = can_fly ? timer : '0;

endmodule

// File: tb/tb_fly_power_ctrl.sv
// Scoreboard bench for fly_power_ctrl: a frame-count model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_fly_power_ctrl;

  localparam int TW    = 10;
  localparam int FLY   = 20;
  localparam int WARN  = 5;
  localparam int GRANT = 4;
  localparam int BLINK = 2;
  localparam int SCORE = 1000;

  logic          sys_clk = 1'b0;
  logic          RST_N = 1'b0;
  logic          frame_tick = 1'b0;
  logic          touch_fly_ms = 1'b0;
  logic          char_hit = 1'b0;
  logic          level_rst = 1'b0;
  logic          can_fly, freeze, sprite_vis, score_vld, hit_absorbed, hit_fatal;
  logic [13:0]   score_add;
  logic [TW-1:0] fly_timer;

  always #5 sys_clk = ~sys_clk;

  fly_power_ctrl #(
    .TIMER_W(TW), .FLY_FRAMES(FLY), .WARN_FRAMES(WARN),
    .GRANT_FRAMES(GRANT), .BLINK_FRAMES(BLINK), .SCORE_VALUE(SCORE)
  ) dut (
    .sys_clk(sys_clk), .RST_N(RST_N), .frame_tick(frame_tick),
    .touch_fly_ms(touch_fly_ms), .char_hit(char_hit), .level_rst(level_rst),
    .can_fly(can_fly), .freeze(freeze), .sprite_vis(sprite_vis),
    .score_add(score_add), .score_vld(score_vld), .hit_absorbed(hit_absorbed),
    .hit_fatal(hit_fatal), .fly_timer(fly_timer)
  );

  typedef struct packed {
    logic          can_fly;
    logic          freeze;
    logic          vis;
    logic          sv;
    logic [13:0]   sa;
    logic          ha;
    logic          hf;
    logic [TW-1:0] ft;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;

  // model: power-up described only by frames left in the grant and in flight
  int grant_left = 0;
  int fly_left   = 0;
  int ph_ticks   = 0;

  function automatic obs_t predict(input logic sv, input logic ha, input logic hf);
    obs_t o;
    bit in_grant, flying, warn;
    in_grant  = grant_left > 0;
    flying    = !in_grant && fly_left > 0;
    warn      = flying && fly_left <= WARN;
    o.can_fly = flying;
    o.freeze  = in_grant;
    o.vis     = (in_grant || warn) ? (((ph_ticks / BLINK) % 2) == 0) : 1'b1;
    o.sv      = sv;
    o.sa      = sv ? 14'(SCORE) : 14'd0;
    o.ha      = ha;
    o.hf      = hf;
    o.ft      = flying ? TW'(fly_left) : '0;
    return o;
  endfunction

  always @(posedge sys_clk) begin : model
    logic sv, ha, hf;
    sv = 1'b0; ha = 1'b0; hf = 1'b0;
    if (!RST_N || level_rst) begin
      grant_left = 0; fly_left = 0; ph_ticks = 0;
    end else if (grant_left > 0) begin
      sv = touch_fly_ms;
      if (frame_tick) begin
        grant_left--;
        ph_ticks++;
        if (grant_left == 0) fly_left = FLY;
      end
    end else if (fly_left > 0) begin
      if (char_hit) begin
        fly_left = 0; ha = 1'b1;
      end else if (touch_fly_ms) begin
        fly_left = FLY; sv = 1'b1;
      end else if (frame_tick) begin
        fly_left--;
        if (fly_left == WARN) ph_ticks = 0;
        else ph_ticks++;
      end
    end else begin
      if (char_hit) hf = 1'b1;
      else if (touch_fly_ms) begin
        grant_left = GRANT; ph_ticks = 0; sv = 1'b1;
      end
    end
    exp_q.push_back(predict(sv, ha, hf));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge sys_clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("can_fly",      32'(can_fly),      32'(e.can_fly));
      check("freeze",       32'(freeze),       32'(e.freeze));
      check("sprite_vis",   32'(sprite_vis),   32'(e.vis));
      check("score_vld",    32'(score_vld),    32'(e.sv));
      check("score_add",    32'(score_add),    32'(e.sa));
      check("hit_absorbed", 32'(hit_absorbed), 32'(e.ha));
      check("hit_fatal",    32'(hit_fatal),    32'(e.hf));
      check("fly_timer",    32'(fly_timer),    32'(e.ft));
    end
  end

  task automatic cyc(input logic t, input logic h, input logic l);
    @(posedge sys_clk);
    #1;
    cyc_n++;
    frame_tick   = (cyc_n % 4 == 0);
    touch_fly_ms = t;
    char_hit     = h;
    level_rst    = l;
  endtask

  function automatic bit cond(input int k);
    case (k)
      0:       return grant_left == 0 && fly_left > WARN;
      1:       return grant_left == 0 && fly_left == 12;
      2:       return grant_left == 0 && fly_left == 3;
      3:       return grant_left == 0 && fly_left == 0;
      default: return grant_left == 0 && fly_left > 0 && fly_left <= WARN;
    endcase
  endfunction

  task automatic wait_for(input int k, input string name);
    int n;
    n = 0;
    while (!cond(k) && n < 400) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!cond(k)) begin
      tests++;
      fails++;
      $display("FAIL wait_%s: got timeout after %0d cycles, required condition reached", name, n);
    end
  endtask

  initial begin
    // touch while held in reset must be ignored
    RST_N = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    wait_for(1, "timer12");
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    wait_for(2, "timer3");
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    wait_for(3, "expiry");

    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    wait_for(0, "flying");
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    wait_for(4, "warn");
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      RST_N = ($urandom_range(0, 799) != 0);
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 499) == 0);
    end

    RST_N = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    @(negedge sys_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
